// File: rtl/div_seq_signed.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor,
// radix-2 restoring on magnitudes, one quotient bit per clock.
// Ports: CLK_100MHz, nRST (async, low), START, A, B in;
//   Q, R, BUSY, DONE, DIV_ZERO, OVF out.
// Optional: `define DIV_SEQ_SIGNED_CHECK_EN adds CHECK_ERR.
module div_seq_signed #(
  parameter int WIDTH = 6
) (
  input  logic               CLK_100MHz,
  input  logic               nRST,
  input  logic               START,
  input  logic [2*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Q,
  output logic [WIDTH-1:0]   R,
  output logic               BUSY,
  output logic               DONE,
  output logic               DIV_ZERO,
`ifdef DIV_SEQ_SIGNED_CHECK_EN
  output logic               OVF,
  output logic               CHECK_ERR
`else
  output logic               OVF
`endif
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Holds remaining dividend bits; quotient bits shift in at the LSB.
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH:0]    bmag_q, bmag_d;
  logic              sa_q, sa_d;
  logic              sq_q, sq_d;
  logic              dz_q, dz_d;
  logic              ov_q, ov_d;
  logic [DW-1:0]     q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              done_q, done_d;
  logic              divz_q, divz_d;
  logic              ovf_q, ovf_d;

  logic [DW-1:0]     a_mag;
  logic [WIDTH:0]    b_mag;
  logic [WIDTH:0]    shifted;
  logic              ge;
  logic [DW-1:0]     q_res;
  logic [WIDTH-1:0]  r_res;

  always_comb begin
    a_mag   = A[DW-1] ? (~A + DW'(1)) : A;
    b_mag   = {1'b0, B[WIDTH-1] ? (~B + WIDTH'(1)) : B};
    shifted = {rem_q, dvd_q[DW-1]};
    ge      = (shifted >= bmag_q);
  end

  always_comb begin
    q_res = sq_q ? (~dvd_q + DW'(1)) : dvd_q;
    r_res = sa_q ? (~rem_q + WIDTH'(1)) : rem_q;
    if (dz_q) begin
      q_res = sa_q ? QMIN : QMAX;
      r_res = '0;
    end else if (ov_q) begin
      q_res = QMAX;
      r_res = '0;
    end
  end

`ifdef DIV_SEQ_SIGNED_CHECK_EN
  localparam int TW = 3 * WIDTH;
  logic [DW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             chk_q, chk_d;
  logic [TW-1:0]    recon;

  always_comb begin
    recon = TW'($signed(q_res)) * TW'($signed(b_q))
          + TW'($signed(r_res));
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    divz_d  = divz_q;
    ovf_d   = ovf_q;
`ifdef DIV_SEQ_SIGNED_CHECK_EN
    a_d     = a_q;
    b_d     = b_q;
    chk_d   = chk_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CALC;
          cnt_d   = '0;
          dvd_d   = a_mag;
          rem_d   = '0;
          bmag_d  = b_mag;
          sa_d    = A[DW-1];
          sq_d    = A[DW-1] ^ B[WIDTH-1];
          dz_d    = (B == '0);
          ov_d    = (A == QMIN) && (B == '1);
`ifdef DIV_SEQ_SIGNED_CHECK_EN
          a_d     = A;
          b_d     = B;
`endif
        end
      end
      S_CALC: begin
        rem_d = ge ? WIDTH'(shifted - bmag_q) : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[DW-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        q_d     = q_res;
        r_d     = r_res;
        done_d  = 1'b1;
        divz_d  = dz_q;
        ovf_d   = ov_q & ~dz_q;
`ifdef DIV_SEQ_SIGNED_CHECK_EN
        chk_d   = ~(dz_q | ov_q) && (recon != TW'($signed(a_q)));
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      sa_q    <= sa_d;
      sq_q    <= sq_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DIV_SEQ_SIGNED_CHECK_EN
  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      a_q   <= '0;
      b_q   <= '0;
      chk_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      chk_q <= chk_d;
    end
  end

  assign CHECK_ERR = chk_q;
`endif

  assign Q        = q_q;
  assign R        = r_q;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = done_q;
  assign DIV_ZERO = divz_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_div_seq_signed.sv
// Bench for div_seq_signed (WIDTH=6): directed cases plus random
// operands against a cycle-level arithmetic model.
module tb_div_seq_signed;

  localparam int W    = 6;
  localparam int DW   = 2 * W;
  localparam int LAT  = 2 * W + 1;
  localparam int QMAX = (1 << (DW - 1)) - 1;
  localparam int QMIN = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [W-1:0]  b = '0;
  logic [DW-1:0] q;
  logic [W-1:0]  r;
  logic          busy, done, dz, ovf;
`ifdef DIV_SEQ_SIGNED_CHECK_EN
  logic          chk_err;
`endif

  div_seq_signed #(.WIDTH(W)) dut (
    .CLK_100MHz(clk),
    .nRST      (nrst),
    .START     (start),
    .A         (a),
    .B         (b),
    .Q         (q),
    .R         (r),
    .BUSY      (busy),
    .DONE      (done),
    .DIV_ZERO  (dz),
`ifdef DIV_SEQ_SIGNED_CHECK_EN
    .OVF       (ovf),
    .CHECK_ERR (chk_err)
`else
    .OVF       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input int ai, input int bi,
                                  output int qo, output int ro,
                                  output bit dzo, output bit ovo);
    dzo = 0;
    ovo = 0;
    if (bi == 0) begin
      qo  = (ai >= 0) ? QMAX : QMIN;
      ro  = 0;
      dzo = 1;
    end else if (ai == QMIN && bi == -1) begin
      qo  = QMAX;
      ro  = 0;
      ovo = 1;
    end else begin
      qo = ai / bi;
      ro = ai % bi;
    end
  endfunction

  // Model: cycles left until completion, pending result, held outputs.
  int m_cnt, m_q, m_r, p_q, p_r;
  bit m_dz, m_ov, m_done, p_dz, p_ov;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_cnt  = 0;
      m_q    = 0;
      m_r    = 0;
      m_dz   = 0;
      m_ov   = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt = LAT;
          ref_div(int'($signed(a)), int'($signed(b)),
                  p_q, p_r, p_dz, p_ov);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_q    = p_q;
          m_r    = p_r;
          m_dz   = p_dz;
          m_ov   = p_ov;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      chk("busy", int'(busy), int'(m_cnt > 0));
      chk("done", int'(done), int'(m_done));
      chk("q", int'($signed(q)), m_q);
      chk("r", int'($signed(r)), m_r);
      chk("div_zero", int'(dz), int'(m_dz));
      chk("ovf", int'(ovf), int'(m_ov));
`ifdef DIV_SEQ_SIGNED_CHECK_EN
      chk("check_err", int'(chk_err), 0);
`endif
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic go(input int ai, input int bi, output int lat);
    @(negedge clk);
    a     = DW'(ai);
    b     = W'(bi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic run_op(input string name, input int ai, input int bi,
                        input int eq, input int er,
                        input int edz, input int eov);
    int lat;
    go(ai, bi, lat);
    chk({name, "_lat"}, lat, LAT);
    chk({name, "_q"}, int'($signed(q)), eq);
    chk({name, "_r"}, int'($signed(r)), er);
    chk({name, "_dz"}, int'(dz), edz);
    chk({name, "_ovf"}, int'(ovf), eov);
  endtask

  initial begin
    int lat;
    int ai, bi;
    int ca[4];
    int cb[5];
    ca = '{QMIN, QMAX, 0, -1};
    cb = '{0, -1, 1, -32, 31};

    #2;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({dz, ovf}), 0);
    @(negedge clk);
    nrst = 1'b1;

    // First op: track BUSY over the whole latency.
    @(negedge clk);
    a = DW'(-35);
    b = W'(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      chk("t1_busy", int'(busy), 1);
      @(negedge clk);
      lat++;
    end
    chk("t1_lat", lat, LAT);
    chk("t1_busy_at_done", int'(busy), 0);
    chk("t1_q", int'($signed(q)), -5);
    chk("t1_r", int'($signed(r)), -5);
    chk("t1_flags", int'({dz, ovf}), 0);

    run_op("t2", 1000, -7, -142, 6, 0, 0);
    run_op("t3", 2047, 1, 2047, 0, 0, 0);
    run_op("ovf", -2048, -1, 2047, 0, 0, 1);
    run_op("dz_pos", 100, 0, 2047, 0, 1, 0);
    run_op("dz_neg", -100, 0, -2048, 0, 1, 0);
    run_op("t4", -35, 6, -5, -5, 0, 0);

    // START during BUSY with new operands must be ignored.
    @(negedge clk);
    a = DW'(-1000);
    b = W'(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = DW'(5);
    b = W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_q", int'($signed(q)), -111);
    chk("ign_r", int'($signed(r)), -1);

    // START held across DONE: back-to-back.
    @(negedge clk);
    a = DW'(1000);
    b = W'(-7);
    start = 1'b1;
    @(negedge clk);
    wait_done(lat);
    chk("b2b_q1", int'($signed(q)), -142);
    a = DW'(2047);
    b = W'(1);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("b2b_lat", lat, LAT);
    chk("b2b_q2", int'($signed(q)), 2047);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    a = DW'(-700);
    b = W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("mrst_q", int'(q), 0);
    chk("mrst_r", int'(r), 0);
    chk("mrst_bd", int'({busy, done}), 0);
    chk("mrst_flags", int'({dz, ovf}), 0);
    @(negedge clk);
    nrst = 1'b1;
    run_op("after_rst", 77, 5, 15, 2, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ai = ca[$urandom_range(0, 3)];
        bi = cb[$urandom_range(0, 4)];
      end else begin
        ai = int'($urandom_range(0, 4095)) - 2048;
        bi = int'($urandom_range(0, 63)) - 32;
      end
      go(ai, bi, lat);
      chk("rand_lat", lat, LAT);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
